// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-issue instruction queue between fetch and id_stage.
// Accepts up to two instructions per cycle and presents the two oldest
// entries as the a/b decode slots. It pops 0/1/2 entries per cycle and
// discards its contents on flush.
// Optional feature: define FETCH_BUFFER_BYPASS_EN for zero-latency
// fetch-to-decode forwarding when the queue is empty.

package fetch_buffer_pkg;
  typedef logic [5:0] exception_t;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_a_valid,
  input  logic             in_b_valid,
  input  logic [31:0]      in_a_pc,
  input  logic [31:0]      in_b_pc,
  input  logic [31:0]      in_a_inst,
  input  logic [31:0]      in_b_inst,
  input  logic             in_a_pred_branch_taken,
  input  logic             in_b_pred_branch_taken,
  input  logic [31:0]      in_a_pred_branch_target,
  input  logic [31:0]      in_b_pred_branch_target,
  input  logic             in_a_have_exception,
  input  logic             in_b_have_exception,
  input  exception_t       in_a_exception_type,
  input  exception_t       in_b_exception_type,
  output logic             in_ready,
  input  logic [1:0]       consume,
  output logic             a_valid,
  output logic             b_valid,
  output logic [31:0]      a_pc,
  output logic [31:0]      b_pc,
  output logic [31:0]      a_inst,
  output logic [31:0]      b_inst,
  output logic             a_pred_branch_taken,
  output logic             b_pred_branch_taken,
  output logic [31:0]      a_pred_branch_target,
  output logic [31:0]      b_pred_branch_target,
  output logic             a_have_exception,
  output logic             b_have_exception,
  output exception_t       a_exception_type,
  output exception_t       b_exception_type,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        have_exc;
    exception_t  exc_type;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [AW-1:0]   rp_r;
  logic [AW-1:0]   wp_r;
  logic [CW-1:0]   count_r;

  entry_t          in_a_s;
  entry_t          in_b_s;
  logic            ready_s;
  logic            push_a_s;
  logic            push_b_s;
  logic [CW-1:0]   push_n_s;
  logic [CW-1:0]   cons_s;
  logic [CW-1:0]   pop_n_s;
  logic [CW-1:0]   wr_n_s;
  logic            wr0_en_s;
  logic            wr1_en_s;
  entry_t          wr0_s;
  entry_t          wr1_s;
  logic            a_valid_s;
  logic            b_valid_s;
  entry_t          a_src_s;
  entry_t          b_src_s;
  entry_t          a_out_s;
  entry_t          b_out_s;

  assign in_a_s = '{pc: in_a_pc, inst: in_a_inst, pred_taken: in_a_pred_branch_taken,
                    pred_target: in_a_pred_branch_target, have_exc: in_a_have_exception,
                    exc_type: in_a_exception_type};
  assign in_b_s = '{pc: in_b_pc, inst: in_b_inst, pred_taken: in_b_pred_branch_taken,
                    pred_target: in_b_pred_branch_target, have_exc: in_b_have_exception,
                    exc_type: in_b_exception_type};

  // Push/pop amounts and write-port selection; ready uses registered count only.
  always_comb begin
    ready_s  = (count_r <= CW'(DEPTH - 2));
    // slot b without slot a is ignored entirely
    push_a_s = ready_s & in_a_valid & ~flush;
    push_b_s = push_a_s & in_b_valid;
    push_n_s = CW'(push_a_s) + CW'(push_b_s);
    cons_s   = CW'(consume);
    // clamp pops to occupancy so a bad consume can never underflow
    if (flush) begin
      pop_n_s = CW'(0);
    end else if (cons_s < count_r) begin
      pop_n_s = cons_s;
    end else begin
      pop_n_s = count_r;
    end
    wr_n_s   = push_n_s;
    wr0_en_s = push_a_s;
    wr1_en_s = push_b_s;
    wr0_s    = in_a_s;
    wr1_s    = in_b_s;
`ifdef FETCH_BUFFER_BYPASS_EN
    // when empty, entries consumed straight from the inputs are never stored
    if ((count_r == CW'(0)) && !flush) begin
      if (cons_s >= push_n_s) begin
        wr_n_s   = CW'(0);
        wr0_en_s = 1'b0;
        wr1_en_s = 1'b0;
      end else if (cons_s == CW'(1)) begin
        wr_n_s   = push_n_s - CW'(1);
        wr0_en_s = push_b_s;
        wr0_s    = in_b_s;
        wr1_en_s = 1'b0;
      end else begin
        wr_n_s   = push_n_s;
      end
    end else begin
      wr_n_s   = push_n_s;
    end
`endif
  end

  // Pointer and occupancy state; reset wins over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp_r    <= AW'(0);
      wp_r    <= AW'(0);
      count_r <= CW'(0);
    end else if (flush) begin
      rp_r    <= AW'(0);
      wp_r    <= AW'(0);
      count_r <= CW'(0);
    end else begin
      rp_r    <= rp_r + pop_n_s[AW-1:0];
      wp_r    <= wp_r + wr_n_s[AW-1:0];
      count_r <= count_r + wr_n_s - pop_n_s;
    end
  end

  // Entry storage; deliberately not reset since outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (wr0_en_s) begin
      mem_r[wp_r] <= wr0_s;
    end
    if (wr1_en_s) begin
      mem_r[wp_r + AW'(1)] <= wr1_s;
    end
  end

  // Head/head+1 selection with valid gating of all data fields.
  always_comb begin
    a_valid_s = (count_r != CW'(0));
    b_valid_s = (count_r >= CW'(2));
    a_src_s   = mem_r[rp_r];
    b_src_s   = mem_r[rp_r + AW'(1)];
`ifdef FETCH_BUFFER_BYPASS_EN
    // empty queue forwards the fetch packet combinationally
    if ((count_r == CW'(0)) && !flush) begin
      a_valid_s = in_a_valid;
      b_valid_s = in_a_valid & in_b_valid;
      a_src_s   = in_a_s;
      b_src_s   = in_b_s;
    end else begin
      a_src_s   = mem_r[rp_r];
    end
`endif
    if (a_valid_s) begin
      a_out_s = a_src_s;
    end else begin
      a_out_s = '0;
    end
    if (b_valid_s) begin
      b_out_s = b_src_s;
    end else begin
      b_out_s = '0;
    end
  end

  assign in_ready             = ready_s;
  assign count                = count_r;
  assign a_valid              = a_valid_s;
  assign b_valid              = b_valid_s;
  assign a_pc                 = a_out_s.pc;
  assign b_pc                 = b_out_s.pc;
  assign a_inst               = a_out_s.inst;
  assign b_inst               = b_out_s.inst;
  assign a_pred_branch_taken  = a_out_s.pred_taken;
  assign b_pred_branch_taken  = b_out_s.pred_taken;
  assign a_pred_branch_target = a_out_s.pred_target;
  assign b_pred_branch_target = b_out_s.pred_target;
  assign a_have_exception     = a_out_s.have_exc;
  assign b_have_exception     = b_out_s.have_exc;
  assign a_exception_type     = a_out_s.exc_type;
  assign b_exception_type     = b_out_s.exc_type;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scoreboard bench for fetch_buffer (DEPTH=8).
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush, in_a_valid, in_b_valid, in_ready, a_valid, b_valid;
  logic [31:0] in_a_pc, in_b_pc, in_a_inst, in_b_inst;
  logic in_a_pred_branch_taken, in_b_pred_branch_taken;
  logic [31:0] in_a_pred_branch_target, in_b_pred_branch_target;
  logic in_a_have_exception, in_b_have_exception;
  exception_t in_a_exception_type, in_b_exception_type;
  logic [1:0] consume;
  logic [31:0] a_pc, b_pc, a_inst, b_inst;
  logic a_pred_branch_taken, b_pred_branch_taken;
  logic [31:0] a_pred_branch_target, b_pred_branch_target;
  logic a_have_exception, b_have_exception;
  exception_t a_exception_type, b_exception_type;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [31:0] next_pc = 32'h1c00_0000;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
    .in_a_pc(in_a_pc), .in_b_pc(in_b_pc),
    .in_a_inst(in_a_inst), .in_b_inst(in_b_inst),
    .in_a_pred_branch_taken(in_a_pred_branch_taken), .in_b_pred_branch_taken(in_b_pred_branch_taken),
    .in_a_pred_branch_target(in_a_pred_branch_target), .in_b_pred_branch_target(in_b_pred_branch_target),
    .in_a_have_exception(in_a_have_exception), .in_b_have_exception(in_b_have_exception),
    .in_a_exception_type(in_a_exception_type), .in_b_exception_type(in_b_exception_type),
    .in_ready(in_ready), .consume(consume),
    .a_valid(a_valid), .b_valid(b_valid),
    .a_pc(a_pc), .b_pc(b_pc), .a_inst(a_inst), .b_inst(b_inst),
    .a_pred_branch_taken(a_pred_branch_taken), .b_pred_branch_taken(b_pred_branch_taken),
    .a_pred_branch_target(a_pred_branch_target), .b_pred_branch_target(b_pred_branch_target),
    .a_have_exception(a_have_exception), .b_have_exception(b_have_exception),
    .a_exception_type(a_exception_type), .b_exception_type(b_exception_type),
    .count(count)
  );

  // side fields are pure functions of pc so the scoreboard only tracks pcs
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hdead_beef;
  endfunction
  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    return pc + 32'h0000_0100;
  endfunction
  function automatic exception_t exc_of(input logic [31:0] pc);
    return exception_t'(pc[7:2] ^ 6'h2a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    logic [31:0] ea, eb;
    n  = q.size();
    ea = (n >= 1) ? q[0] : 32'h0;
    eb = (n >= 2) ? q[1] : 32'h0;
    chk("count", 64'(count), 64'(n));
    chk("a_valid", 64'(a_valid), 64'(n >= 1));
    chk("b_valid", 64'(b_valid), 64'(n >= 2));
    chk("in_ready", 64'(in_ready), 64'(n <= DEPTH - 2));
    chk("a_pc", 64'(a_pc), 64'(ea));
    chk("b_pc", 64'(b_pc), 64'(eb));
    chk("a_inst", 64'(a_inst), 64'((n >= 1) ? inst_of(ea) : 32'h0));
    chk("b_inst", 64'(b_inst), 64'((n >= 2) ? inst_of(eb) : 32'h0));
    chk("a_target", 64'(a_pred_branch_target), 64'((n >= 1) ? tgt_of(ea) : 32'h0));
    chk("b_taken", 64'(b_pred_branch_taken), 64'((n >= 2) ? eb[2] : 1'b0));
    chk("a_exc", 64'({a_have_exception, a_exception_type}),
        64'((n >= 1) ? {ea[3], exc_of(ea)} : 7'h0));
    chk("b_exc", 64'({b_have_exception, b_exception_type}),
        64'((n >= 2) ? {eb[3], exc_of(eb)} : 7'h0));
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic va, input logic vb,
                       input logic [1:0] cons);
    logic [31:0] pa, pb;
    logic rdy;
    logic [31:0] pushed[$];
    int k;
    @(negedge clk);
    pa = next_pc;
    pb = next_pc + 32'd4;
    if (va) next_pc = next_pc + 32'd8;
    reset = rst; flush = fl; consume = cons;
    in_a_valid = va; in_b_valid = vb;
    in_a_pc = pa; in_b_pc = pb;
    in_a_inst = inst_of(pa); in_b_inst = inst_of(pb);
    in_a_pred_branch_taken = pa[2]; in_b_pred_branch_taken = pb[2];
    in_a_pred_branch_target = tgt_of(pa); in_b_pred_branch_target = tgt_of(pb);
    in_a_have_exception = pa[3]; in_b_have_exception = pb[3];
    in_a_exception_type = exc_of(pa); in_b_exception_type = exc_of(pb);
    rdy = (q.size() <= DEPTH - 2);
`ifdef FETCH_BUFFER_BYPASS_EN
    #1;
    if (!rst && !fl && q.size() == 0) begin
      chk("byp_a_valid", 64'(a_valid), 64'(va));
      chk("byp_b_valid", 64'(b_valid), 64'(va & vb));
      chk("byp_a_pc", 64'(a_pc), 64'(va ? pa : 32'h0));
    end
`endif
    @(posedge clk);
    #1;
    if (rst || fl) begin
      q.delete();
    end else begin
      if (rdy && va) begin
        pushed.push_back(pa);
        if (vb) pushed.push_back(pb);
      end
`ifdef FETCH_BUFFER_BYPASS_EN
      if (q.size() == 0) begin
        k = (int'(cons) > pushed.size()) ? pushed.size() : int'(cons);
        repeat (k) void'(pushed.pop_front());
      end
`endif
      k = (int'(cons) > q.size()) ? q.size() : int'(cons);
      repeat (k) void'(q.pop_front());
      foreach (pushed[i]) q.push_back(pushed[i]);
    end
    check_state();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; consume = 2'd0;
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    in_a_pc = 32'h0; in_b_pc = 32'h0; in_a_inst = 32'h0; in_b_inst = 32'h0;
    in_a_pred_branch_taken = 1'b0; in_b_pred_branch_taken = 1'b0;
    in_a_pred_branch_target = 32'h0; in_b_pred_branch_target = 32'h0;
    in_a_have_exception = 1'b0; in_b_have_exception = 1'b0;
    in_a_exception_type = '0; in_b_exception_type = '0;

    // reset then idle
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // first pair 0x1c000000/0x1c000004, then drain (pointers move to 2)
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    // fill to 7 across the wrap, ready drops
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    // at count 7 a push with consume=2 is refused
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    // drain by 2 through the wrap, last consume=2 at count 1
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    // count 3, then push 2 with consume 1
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
    // count 5, flush with push and consume
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // illegal b without a writes nothing
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    // fill exactly to DEPTH, refused push at full
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    // reset mid-operation, with a flush also asserted
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    // push into empty with consume (bypass-relevant), then single
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Dual-issue instruction queue between the fetch stage and `id_stage`. It accepts up to two fetched instructions per cycle, with their PC, prediction and fetch-exception info. It presents the two oldest entries as the `a`/`b` slots of the decoder and pops 0/1/2 entries per cycle according to `id_consume_inst`. A flush discards all contents on branch mispredict or exception redirect.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥ 4.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all entries and this cycle's push.
- `in_a_valid`, `in_b_valid`  in  1 each  fetch slot valid. `in_b_valid` is only legal with `in_a_valid`.
- `in_{a,b}_pc`, `in_{a,b}_inst`  in  32 each  PC and instruction word.
- `in_{a,b}_pred_branch_taken`  in  1  predictor taken.
- `in_{a,b}_pred_branch_target`  in  32  predicted target.
- `in_{a,b}_have_exception`  in  1  fetch-side exception.
- `in_{a,b}_exception_type`  in  `exception_t`  exception code.
- `in_ready`  out  1  buffer can take a full 2-instruction packet.
- `consume`  in  2  entries popped this cycle (0/1/2), driven from `id_consume_inst`.
- `a_valid`, `b_valid`  out  1 each  head / head+1 entry valid.
- `a_*`, `b_*`  out  same fields as `in_*`  head / head+1 entry contents.
- `count`  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters.

## Operation
Storage:
- Circular array of DEPTH entries.
- Read pointer `rp` and write pointer `wp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy register `count`.

Push:
- `push_n` = 0 when `flush`, else `in_ready & in_a_valid` + `in_ready & in_b_valid`.
- Slot `a` is written at `wp`, slot `b` at `wp+1`. `wp` advances by `push_n`.

Ready:
- `in_ready` = (`count` ≤ DEPTH−2).
- Computed from the registered `count` only. It ignores same-cycle pops; this is conservative and keeps the fetch path short.

Pop:
- `pop_n` = min(`consume`, `count`); the clamp protects against a protocol violation.
- `consume`=2 with `count`=1 pops 1.
- `rp` advances by `pop_n`.

Count update:
- `count` ← `count` + `push_n` − `pop_n`.
- Simultaneous push and pop are legal and combine arithmetically.

Outputs:
- `a_valid` = `count` ≥ 1; `b_valid` = `count` ≥ 2.
- `a_*` reads entry `rp`; `b_*` reads entry `rp+1` (mod DEPTH, wraps).
- All data outputs are forced to 0 when their valid is low. Storage itself is not reset.

Flush:
- `count`, `rp` and `wp` go to 0 next cycle.
- Any push in the flush cycle is dropped.
- `consume` in the flush cycle is ignored.

Illegal input:
- `in_b_valid` without `in_a_valid` is treated as no push (nothing is written).

## Timing
- Reset values: `count`=0, `rp`=`wp`=0, `a_valid`=`b_valid`=0, all `a_*`/`b_*`=0, `in_ready`=1.
- Reset has priority over `flush`.
- Reset mid-operation empties the queue next cycle. Stale storage is never visible because outputs are gated by valid.
- Push-to-output latency: 1 cycle. An entry written at edge N is visible on `a_*`/`b_*` after edge N.
- Pop effect: the decoder sees the new head after the same edge that applied `consume`.
- Full boundary:
  - At `count`=DEPTH−1, `in_ready`=0 even if `consume`=2 that cycle.
  - At `count`=DEPTH−2, a 2-instruction push fills the buffer exactly.
- Pointer wrap is silent. Entries at index DEPTH−1 and 0 form a valid a/b pair.
- `count` never exceeds DEPTH and never underflows.

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined:
  - When `count`=0 and not `flush`, incoming `in_a`/`in_b` appear combinationally on `a_*`/`b_*` with `a_valid`/`b_valid` set in the same cycle.
  - Entries covered by `consume` that cycle are not written. `wp` and `count` advance only by `push_n` − `consume`, clamped at ≥ 0.
  - Zero-latency fetch-to-decode when empty.
- Undefined: no bypass; 1-cycle latency always, per Timing.

## Test plan
- Reset then idle: `count`=0, `a_valid`=0, `in_ready`=1, `a_pc`=0.
- Push {0x1c000000, 0x1c000004} with `consume`=0; next cycle `a_pc`=0x1c000000, `b_pc`=0x1c000004, `count`=2.
- Fill to 8 entries (DEPTH=8):
  - `in_ready` drops at `count`=7.
  - Then `consume`=2 each cycle with no push; `a_pc` steps by 8 and order survives wrap at index 7→0.
- `count`=3, push 2 and `consume`=1 together → `count`=4, `a_pc` advances by one entry.
- `count`=5 with `flush`=1, `in_a_valid`=1, `consume`=2 → next cycle `count`=0, `a_valid`=0, nothing written.
- `count`=1, `consume`=2 → `count`=0, no underflow.
- With `FETCH_BUFFER_BYPASS_EN`: empty buffer, push a/b with `consume`=2 → `a_valid`=`b_valid`=1 same cycle, `count` stays 0.
